ln_request_scheduler: RTL

// - Shares one pipelined natural-log datapath (divide + atanh, Q12.24, ln = 2*atanh((w-1)/(w+1))) between two requesters.
// - Round-robin arbitration, operand range check, in-flight tag tracking, tagged result return.
// - Sits between client blocks and the ln datapath; the datapath has no valid/ready, so this block owns all sequencing.

---
 rtl/ln_request_scheduler.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ln_request_scheduler.sv
// ln_request_scheduler: shares one pipelined ln datapath between two requesters.
// Round-robin arbitration, operand range check, in-flight tag tracking and
// tagged response return with a fixed accept->response latency of LN_LATENCY+2.
// Optional build macro: LN_RANGE_SAT_EN (clamp positive over-range operands to
// W_MAX instead of rejecting them; the response is still flagged as an error).
module ln_request_scheduler #(
  parameter int unsigned LN_LATENCY = 40,
  parameter int unsigned ISSUE_GAP  = 1,
  parameter logic [35:0] W_MAX      = 36'h014000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [35:0] req0_w,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [35:0] req1_w,
  output logic        req1_ready,
  output logic [35:0] dp_w,
  input  logic [35:0] dp_ln,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [35:0] rsp_ln,
  output logic        rsp_err
);

  localparam int unsigned W_W   = 36;
  localparam int unsigned GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [W_W-1:0] W_ONE = 36'h001000000;

  // zero_ln forces rsp_ln to 0; differs from err only for clamped operands
  typedef struct packed {
    logic valid;
    logic id;
    logic err;
    logic zero_ln;
  } tag_t;

  logic             last_id;
  logic [GAP_W-1:0] gap_cnt;
  tag_t             iss_tag;
  tag_t             tag_pipe [0:LN_LATENCY-1];
  tag_t             tail_tag;

  logic             gap_open_c;
  logic             grant0_c;
  logic             grant1_c;
  logic             acc0_c;
  logic             acc1_c;
  logic [W_W-1:0]   acc_w_c;
  logic             in_range_c;
  logic [W_W-1:0]   issue_w_c;
  tag_t             issue_tag_c;

  // Round-robin grant: on contention favour the requester not granted last
  assign gap_open_c = (gap_cnt == '0);
  assign grant0_c   = req0_valid && (!req1_valid || last_id);
  assign grant1_c   = req1_valid && (!req0_valid || !last_id);
  assign req0_ready = grant0_c && gap_open_c && !rst;
  assign req1_ready = grant1_c && gap_open_c && !rst;
  assign acc0_c     = req0_valid && req0_ready;
  assign acc1_c     = req1_valid && req1_ready;
  assign acc_w_c    = acc1_c ? req1_w : req0_w;
  assign in_range_c = (acc_w_c != '0) && !acc_w_c[W_W-1] && (acc_w_c <= W_MAX);
  assign tail_tag   = tag_pipe[LN_LATENCY-1];

  // Operand and tag for the accepted request; rejected operands issue 1.0
  always_comb begin
    issue_w_c   = W_ONE;
    issue_tag_c = '0;
    if (acc0_c || acc1_c) begin
      issue_tag_c.valid   = 1'b1;
      issue_tag_c.id      = acc1_c;
      issue_tag_c.err     = !in_range_c;
      issue_tag_c.zero_ln = !in_range_c;
      if (in_range_c) begin
        issue_w_c = acc_w_c;
      end
`ifdef LN_RANGE_SAT_EN
      else if ((acc_w_c != '0) && !acc_w_c[W_W-1]) begin
        issue_w_c           = W_MAX;
        issue_tag_c.zero_ln = 1'b0;
      end
`endif
    end
  end

  // Issue stage: datapath operand, issue tag, arbitration pointer, gap counter
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_w    <= W_ONE;
      iss_tag <= '0;
      last_id <= 1'b0;
      gap_cnt <= '0;
    end else begin
      iss_tag <= issue_tag_c;
      if (acc0_c || acc1_c) begin
        dp_w    <= issue_w_c;
        last_id <= acc1_c;
        gap_cnt <= GAP_W'(ISSUE_GAP - 1);
      end else if (!gap_open_c) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

  // Tag pipe mirrors the datapath stages so the tail lines up with dp_ln
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(LN_LATENCY); i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= iss_tag;
      for (int i = 1; i < int'(LN_LATENCY); i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // Response register: capture dp_ln alongside the exiting tag
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_ln    <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= tail_tag.valid;
      if (tail_tag.valid) begin
        rsp_id  <= tail_tag.id;
        rsp_err <= tail_tag.err;
        rsp_ln  <= tail_tag.zero_ln ? '0 : dp_ln;
      end
    end
  end

endmodule
